counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_pkg.sv | 24 ++
 rtl/counter_rst_sync.sv | 33 +++
 rtl/counter.sv | 77 +++++++
 tb/tb_counter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants and helper functions for the counter block.
//   DEFAULT_N    : default MSB index of the count (count width is N+1 bits).
//   default_max  : terminal count for a plain N+1-bit binary counter.
//   to_gray      : binary-to-Gray conversion on a 32-bit container; callers
//                  truncate the result to their own width.
package counter_pkg;

  localparam int DEFAULT_N = 7;

  // Largest value representable in n+1 bits, used as the default terminal
  // count so the counter overflows naturally from all-ones to zero.
  function automatic int unsigned default_max(input int n);
    int unsigned one;
    one = 1;
    return (one << (n + 1)) - one;
  endfunction

  // Adjacent Gray codes differ in one bit: g = b ^ (b >> 1).
  function automatic logic [31:0] to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/counter_rst_sync.sv
// counter_rst_sync
//   Two-flop reset synchronizer: asserts asynchronously with clear and
//   releases only after two rising edges of clock, so the counter never
//   leaves reset close to an active edge.
//   clock      : counter clock
//   clear      : asynchronous active-low reset input
//   rst_n_sync : active-low reset, async assert / sync deassert
module counter_rst_sync (
  input  logic clock,
  input  logic clear,
  output logic rst_n_sync
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // A constant one shifts in from bit 0; bit 1 drives the released reset.
  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  // Both stages clear immediately when clear drops, without waiting for a clock.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_n_sync = sync_q[1];

endmodule

// File: rtl/counter.sv
// counter
//   Free-running modulo-(MAX+1) up counter with a registered Gray copy,
//   a terminal-count flag and a one-cycle wrap pulse.
//   Parameters:
//     N   : MSB index, count width is N+1 bits (0..30)
//     MAX : terminal count (1..2^(N+1)-1), defaults to all-ones
//   Ports:
//     clock      : rising-edge clock
//     clear      : asynchronous active-low reset (release synchronized)
//     count      : registered binary count
//     count_gray : registered Gray code of count, same cycle as count
//     tc         : high while count == MAX
//     wrap       : high for the single cycle after count steps MAX -> 0
module counter
  import counter_pkg::*;
#(
  parameter int          N   = DEFAULT_N,
  parameter int unsigned MAX = default_max(N)
) (
  input  logic       clock,
  input  logic       clear,
  output logic [N:0] count,
  output logic [N:0] count_gray,
  output logic       tc,
  output logic       wrap
);

  localparam int             W     = N + 1;
  localparam logic [W-1:0]   MAX_W = MAX[W-1:0];
  localparam logic [W-1:0]   ONE_W = W'(1);

  logic         rst_n_sync;
  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] gray_q;
  logic [W-1:0] gray_d;
  logic         wrap_q;
  logic         wrap_d;
  logic         at_max;

  counter_rst_sync u_rst_sync (
    .clock      (clock),
    .clear      (clear),
    .rst_n_sync (rst_n_sync)
  );

  // Next state: step by one, or return to zero from the terminal count.
  // The Gray code is derived from the next count so that it lands in the
  // same register cycle as the binary value. The wrap pulse is armed when
  // the current count is terminal, so it is visible while count reads 0.
  always_comb begin
    at_max  = (count_q == MAX_W);
    count_d = at_max ? '0 : count_q + ONE_W;
    gray_d  = W'(to_gray(32'(count_d)));
    wrap_d  = at_max;
  end

  // All state clears at once when the synchronized reset asserts, which
  // also suppresses any pending wrap pulse if reset hits at the terminal count.
  always_ff @(posedge clock or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      count_q <= '0;
      gray_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      gray_q  <= gray_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count      = count_q;
  assign count_gray = gray_q;
  assign tc         = at_max;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_counter.sv
// tb_counter
//   Directed self-checking bench for counter. Three instances share one
//   20 ns clock (first rising edge at 10 ns):
//     dut_a : N=7, default MAX=255
//     dut_b : N=3, default MAX=15
//     dut_c : N=7, MAX=9
//   Outputs are sampled on falling edges or a few ns after asynchronous
//   reset changes, away from the rising edge.
module tb_counter;

  logic       clock;
  logic       clear_a;
  logic       clear_b;
  logic       clear_c;
  logic [7:0] count_a;
  logic [7:0] gray_a;
  logic       tc_a;
  logic       wrap_a;
  logic [3:0] count_b;
  logic [3:0] gray_b;
  logic       tc_b;
  logic       wrap_b;
  logic [7:0] count_c;
  logic [7:0] gray_c;
  logic       tc_c;
  logic       wrap_c;

  int checks;
  int errors;

  counter #(.N(7)) dut_a (
    .clock      (clock),
    .clear      (clear_a),
    .count      (count_a),
    .count_gray (gray_a),
    .tc         (tc_a),
    .wrap       (wrap_a)
  );

  counter #(.N(3)) dut_b (
    .clock      (clock),
    .clear      (clear_b),
    .count      (count_b),
    .count_gray (gray_b),
    .tc         (tc_b),
    .wrap       (wrap_b)
  );

  counter #(.N(7), .MAX(9)) dut_c (
    .clock      (clock),
    .clear      (clear_c),
    .count      (count_c),
    .count_gray (gray_c),
    .tc         (tc_c),
    .wrap       (wrap_c)
  );

  // 20 ns clock, rising edges at 10, 30, 50, ...
  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  // Safety net so a stuck run still ends with a visible report.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic a, input logic b, input logic c);
    clear_a = a;
    clear_b = b;
    clear_c = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // k = number of counting edges since the synchronized reset release.
  task automatic checkCounter(input string tag, input int k, input int modv,
                              input logic [31:0] obs_count, input logic [31:0] obs_gray,
                              input logic obs_tc, input logic obs_wrap);
    int e;
    e = k % modv;
    checkOutput($sformatf("%s k=%0d count", tag, k), obs_count, e);
    checkOutput($sformatf("%s k=%0d gray", tag, k), obs_gray, e ^ (e >> 1));
    checkOutput($sformatf("%s k=%0d tc", tag, k), {31'd0, obs_tc}, (e == modv - 1) ? 1 : 0);
    checkOutput($sformatf("%s k=%0d wrap", tag, k), {31'd0, obs_wrap},
                (k > 0 && e == 0) ? 1 : 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkCounter({tag, " a"}, 0, 256, count_a, gray_a, tc_a, wrap_a);
    checkCounter({tag, " b"}, 0, 16, count_b, gray_b, tc_b, wrap_b);
    checkCounter({tag, " c"}, 0, 10, count_c, gray_c, tc_c, wrap_c);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset held: zero before and after the 10 ns edge.
    #5;
    checkAllZero("reset_t5");
    @(negedge clock);
    checkAllZero("reset_edge10");

    // Release at 25 ns; edges at 30 and 50 are absorbed by the synchronizer.
    #5;
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clock);
    checkAllZero("sync_edge30");
    @(negedge clock);
    checkAllZero("sync_edge50");

    // Counting from the edge at 70 ns; k=48 is sampled at 1020 ns.
    for (int k = 1; k <= 63; k++) begin
      @(negedge clock);
      checkCounter("run a", k, 256, count_a, gray_a, tc_a, wrap_a);
      checkCounter("run b", k, 16, count_b, gray_b, tc_b, wrap_b);
      checkCounter("run c", k, 10, count_c, gray_c, tc_c, wrap_c);
      if (k == 48) begin
        checkOutput("count48 a", count_a, 48);
      end
    end

    // dut_b sits at its terminal count 15: reset between edges.
    checkOutput("pre_term b count", count_b, 15);
    #3;
    clear_b = 1'b0;
    #1;
    checkCounter("term_reset b", 0, 16, count_b, gray_b, tc_b, wrap_b);

    // Held reset across an edge: no wrap pulse escapes.
    @(negedge clock);
    checkCounter("term_hold b", 0, 16, count_b, gray_b, tc_b, wrap_b);
    checkCounter("run a", 64, 256, count_a, gray_a, tc_a, wrap_a);
    checkCounter("run c", 64, 10, count_c, gray_c, tc_c, wrap_c);

    @(negedge clock);
    checkCounter("term_hold2 b", 0, 16, count_b, gray_b, tc_b, wrap_b);
    checkCounter("run c", 65, 10, count_c, gray_c, tc_c, wrap_c);

    // dut_c at count 5: asynchronous reset between edges.
    #3;
    clear_c = 1'b0;
    #1;
    checkCounter("mid_reset c", 0, 10, count_c, gray_c, tc_c, wrap_c);

    // Re-release both before the next rising edge.
    #3;
    clear_b = 1'b1;
    clear_c = 1'b1;
    @(negedge clock);
    checkCounter("resync1 b", 0, 16, count_b, gray_b, tc_b, wrap_b);
    checkCounter("resync1 c", 0, 10, count_c, gray_c, tc_c, wrap_c);
    @(negedge clock);
    checkCounter("resync2 b", 0, 16, count_b, gray_b, tc_b, wrap_b);
    checkCounter("resync2 c", 0, 10, count_c, gray_c, tc_c, wrap_c);

    for (int j = 1; j <= 22; j++) begin
      @(negedge clock);
      checkCounter("resume b", j, 16, count_b, gray_b, tc_b, wrap_b);
      checkCounter("resume c", j, 10, count_c, gray_c, tc_c, wrap_c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
